decode_cycle: RTL and testbench

//  Decode stage of the 5-stage RV32I pipeline. It consumes InstrD/PCD/PCPlus4D from the fetch stage.
//  It decodes control, reads the 32x32 register file and sign-extends the immediate.

---
 rtl/decode_cycle_pkg.sv | 80 ++++++++
 rtl/decode_cycle_if.sv | 39 +++
 rtl/decode_cycle_register_file.sv | 37 +++
 rtl/decode_cycle.sv | 116 +++++++++++
 tb/tb_decode_cycle.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_cycle_pkg.sv
// Shared RV32I encodings for the fetch/decode/execute slice: opcodes,
// ALU and result-select codes, immediate formats and the ID/EX payload.
package decode_cycle_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_e   alu_control;
    logic        alu_src;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } idex_t;

  // funct3 codes outside add/slt/or/and fall back to add.
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] i, input imm_src_e src);
    case (src)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Decode-stage bus: D-stage instruction/PC and flush in, W-stage write port in,
// registered ID/EX controls and operands out.
interface decode_cycle_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
           RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle_register_file.sv
// 31 x XLEN register file (x0 reads zero) with two read ports, one write port
// and a write-to-read bypass so a W-stage result is visible in the same cycle.
module decode_cycle_register_file
  import decode_cycle_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_hit;

  assign wr_hit = we && (a3 != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[a3] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != 5'd0) rd1 = (wr_hit && a3 == a1) ? wd : regs[a1];
    if (a2 != 5'd0) rd2 = (wr_hit && a3 == a2) ? wd : regs[a2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension and
// the ID/EX pipeline register (bubble on FlushE).
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  ctrl_t           ctrl;
  imm_src_e        imm_src;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  idex_t           idex_d;
  idex_t           idex_q;

  assign instr  = bus.InstrD;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Unknown opcodes, including the all-zero bubble, leave every control at 0.
  always_comb begin
    ctrl    = '0;
    imm_src = IMM_NONE;
    case (opcode)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op(instr[14:12], instr[30]);
      end
      OP_I: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_op(instr[14:12], 1'b0);
        imm_src          = IMM_I;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
        imm_src         = IMM_I;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        imm_src          = IMM_B;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: ;
    endcase
  end

  decode_cycle_register_file u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (rs1),
    .a2  (rs2),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (bus.RegWriteW),
    .a3  (bus.RdW),
    .wd  (bus.ResultW)
  );

  always_comb begin
    idex_d.ctrl     = ctrl;
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.imm      = imm_extend(instr[31:7], imm_src);
    idex_d.rs1      = rs1;
    idex_d.rs2      = rs2;
    idex_d.rd       = rd;
    idex_d.pc       = bus.PCD;
    idex_d.pc_plus4 = bus.PCPlus4D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            idex_q <= '0;
    else if (bus.FlushE) idex_q <= '0;
    else                 idex_q <= idex_d;
  end

  assign bus.RegWriteE   = idex_q.ctrl.reg_write;
  assign bus.ResultSrcE  = idex_q.ctrl.result_src;
  assign bus.MemWriteE   = idex_q.ctrl.mem_write;
  assign bus.JumpE       = idex_q.ctrl.jump;
  assign bus.BranchE     = idex_q.ctrl.branch;
  assign bus.ALUControlE = idex_q.ctrl.alu_control;
  assign bus.ALUSrcE     = idex_q.ctrl.alu_src;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
  assign bus.RdE         = idex_q.rd;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Randomised bench for decode_cycle against a register/decode reference model.
module tb_decode_cycle;
  localparam int W = 153;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_cycle_if bus();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_regs[32];
  logic [31:0]  exp_imm;
  logic         has_imm;
  logic [W-1:0] exp_v;
  int           errors = 0;
  int           checks = 0;

  wire [W-1:0] obs = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                      bus.ALUControlE, bus.ALUSrcE, bus.RD1E, bus.RD2E,
                      bus.Rs1E, bus.Rs2E, bus.RdE, bus.PCE, bus.PCPlus4E};

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
  function automatic logic [9:0] ref_ctrl(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return {1'b1, 2'b00, 3'b000, ref_alu(i[14:12], i[30]), 1'b0};
      7'b0010011: return {1'b1, 2'b00, 3'b000, ref_alu(i[14:12], 1'b0), 1'b1};
      7'b0000011: return {1'b1, 2'b01, 3'b000, 3'b000, 1'b1};
      7'b0100011: return {1'b0, 2'b00, 3'b100, 3'b000, 1'b1};
      7'b1100011: return {1'b0, 2'b00, 3'b001, 3'b001, 1'b0};
      7'b1101111: return {1'b1, 2'b10, 3'b010, 3'b000, 1'b0};
      default:    return 10'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wd;
    return model_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
  endtask

  // Drives one D/W cycle, queues the expected ID/EX contents, advances past the edge.
  task automatic drive(input logic [31:0] instr, input logic flush, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    logic [31:0] pc;
    logic [31:0] i;
    pc = $urandom;
    i  = instr;
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.FlushE    = flush;
    bus.RegWriteW = we;
    bus.RdW       = wr;
    bus.ResultW   = wd;
    has_imm = 1'b1;
    exp_imm = 32'd0;
    if (flush) begin
      exp_q.push_back('0);
    end else begin
      exp_q.push_back({ref_ctrl(i), ref_read(i[19:15], we, wr, wd), ref_read(i[24:20], we, wr, wd),
                       i[19:15], i[24:20], i[11:7], pc, pc + 32'd4});
      case (i[6:0])
        7'b0010011, 7'b0000011: exp_imm = 32'($signed(i[31:20]));
        7'b0100011: exp_imm = 32'($signed({i[31:25], i[11:7]}));
        7'b1100011: exp_imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        7'b1101111: exp_imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        default:    has_imm = 1'b0;
      endcase
    end
    @(posedge clk);
    if (we && wr != 5'd0) model_regs[wr] = wd;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.InstrD = 32'h00500093; bus.PCD = 32'h100; bus.PCPlus4D = 32'h104;
    bus.FlushE = 1'b0; bus.RegWriteW = 1'b0; bus.RdW = 5'd0; bus.ResultW = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0 || bus.ImmExtE !== 32'd0)
      begin errors++; $display("FAIL reset_outputs: got %h imm %h, expected all zero", obs, bus.ImmExtE); end
    rst = 1'b1;
    drive(32'h00008093, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_x1_read: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_addi();
    drive(32'h00500093, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL addi_fields: got %h expected %h", obs, exp_v); end
    checks++;
    if (bus.ImmExtE !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h expected 00000005", bus.ImmExtE); end
  endtask

  task automatic test_bypass();
    drive(32'h002081B3, 1'b0, 1'b1, 5'd1, 32'd5);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bypass_x1: got %h expected %h", obs, exp_v); end
    checks++;
    if (bus.RD1E !== 32'd5 || bus.RdE !== 5'd3 || bus.ALUSrcE !== 1'b0)
      begin errors++; $display("FAIL bypass_rd1: got rd1=%h rd=%0d alusrc=%b expected 5/3/0", bus.RD1E, bus.RdE, bus.ALUSrcE); end
    drive(32'h000001B3, 1'b0, 1'b1, 5'd0, 32'd9);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || bus.RD1E !== 32'd0)
      begin errors++; $display("FAIL bypass_x0: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_immediates();
    logic [31:0] imms[2];
    logic [31:0] ins[2];
    ins[0] = 32'hFE000CE3; imms[0] = 32'hFFFFFFF8;
    ins[1] = 32'h0020A623; imms[1] = 32'd12;
    for (int k = 0; k < 2; k++) begin
      drive(ins[k], 1'b0, 1'b0, 5'd0, 32'd0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL imm_fields_%0d: got %h expected %h", k, obs, exp_v); end
      checks++;
      if (bus.ImmExtE !== imms[k]) begin errors++; $display("FAIL imm_value_%0d: got %h expected %h", k, bus.ImmExtE, imms[k]); end
    end
  endtask

  task automatic test_flush();
    drive(32'h002081B3, 1'b1, 1'b1, 5'd5, 32'h0000DEAD);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || bus.ImmExtE !== 32'd0)
      begin errors++; $display("FAIL flush_bubble: got %h imm %h expected %h", obs, bus.ImmExtE, exp_v); end
    drive(32'h00028333, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || bus.RD1E !== 32'h0000DEAD)
      begin errors++; $display("FAIL flush_wb_kept: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_mid_reset();
    drive(32'h00000000, 1'b0, 1'b1, 5'd7, 32'h00001234);
    void'(exp_q.pop_front());
    drive(32'h00038333, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_x7: got %h expected %h", obs, exp_v); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", obs); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    drive(32'h00038333, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_reset_x7: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_random();
    logic [6:0]  ops[8];
    logic [31:0] instr;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'b0000000;
    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) instr = 32'd0;
      drive(instr, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_%0d: instr %h got %h expected %h", n, instr, obs, exp_v); end
      if (has_imm) begin
        checks++;
        if (bus.ImmExtE !== exp_imm)
          begin errors++; $display("FAIL random_imm_%0d: instr %h got %h expected %h", n, instr, bus.ImmExtE, exp_imm); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_immediates();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
